// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampled UART blocks.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_ODD,
        PAR_EVEN
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK_WAIT
    } rx_state_e;

    // Rounded clock divider: clocks per oversample tick.
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        longint unsigned den;
        den = longint'(baud) * longint'(os);
        return int'((longint'(clk_hz) + den / 2) / den);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator with per-bit sample index and mid/boundary strobes.
module uart_baud_tick #(
    parameter int DIV        = 27,
    parameter int OVERSAMPLE = 16,
    localparam int CW        = (DIV > 1) ? $clog2(DIV) : 1,
    localparam int SW        = $clog2(OVERSAMPLE)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          restart_i,
    input  logic          enable_i,
    output logic          tick_o,
    output logic [SW-1:0] sidx_o,
    output logic          mid_o,
    output logic          bound_o
);

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_MID    = SW'(OVERSAMPLE / 2 + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] s_q, s_d;

    assign tick_o  = enable_i && !restart_i && (cnt_q == CNT_LAST);
    assign sidx_o  = s_q;
    assign mid_o   = tick_o && (s_q == S_MID);
    assign bound_o = tick_o && (s_q == S_LAST);

    always_comb begin
        cnt_d = cnt_q;
        s_d   = s_q;
        if (restart_i || !enable_i) begin
            cnt_d = '0;
            s_d   = '0;
        end else if (tick_o) begin
            cnt_d = '0;
            s_d   = (s_q == S_LAST) ? '0 : s_q + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            s_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            s_q   <= s_d;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: majority-vote sampling, parity/framing/break
// detection, and a single-entry valid/ready output register with overrun flag.
module uart_rx_os import uart_pkg::*; #(
    parameter int      CLK_HZ      = 50_000_000,
    parameter int      BAUD        = 115200,
    parameter int      OVERSAMPLE  = 16,
    parameter int      DATA_BITS   = 8,
    parameter parity_e PARITY      = PAR_NONE,
    parameter int      STOP_BITS   = 1,
    parameter int      SYNC_STAGES = 2
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_parity_err,
    output logic                 m_frame_err,
    output logic                 m_break,
    output logic                 overrun,
    output logic                 busy
);

    localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);
    localparam logic [SW-1:0] S_V0      = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_V1      = SW'(OVERSAMPLE / 2);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    if (DIV < 2 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 ||
        DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 || SYNC_STAGES < 2) begin : g_param_chk
        $error("uart_rx_os: unsupported parameter set (DIV=%0d)", DIV);
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   line, fall;

    rx_state_e              state_q, state_d;
    logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
    logic                   stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   perr_q, perr_d, ferr_q, ferr_d;
    logic                   par_bit_q, par_bit_d, fs0_q, fs0_d;
    logic [1:0]             vote_q, vote_d;
    logic                   bit_val, par_exp, complete, brk, ferr_fin;

    logic [DATA_BITS-1:0]   m_data_q, m_data_d;
    logic                   m_valid_q, m_valid_d, m_perr_q, m_perr_d;
    logic                   m_ferr_q, m_ferr_d, m_brk_q, m_brk_d, overrun_q, overrun_d;

    logic                   tick, mid, bound;
    logic [SW-1:0]          sidx;

    assign line = sync_q[SYNC_STAGES-1];
    assign fall = prev_q && !line;

    uart_baud_tick #(
        .DIV        (DIV),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .clk_i     (aclk),
        .rst_i     (areset),
        .restart_i (fall && (state_q == IDLE)),
        .enable_i  (state_q != IDLE),
        .tick_o    (tick),
        .sidx_o    (sidx),
        .mid_o     (mid),
        .bound_o   (bound)
    );

    // Third vote is the live line at the decision sample.
    assign bit_val = (vote_q[0] & vote_q[1]) | (vote_q[0] & line) | (vote_q[1] & line);
    assign par_exp = (PARITY == PAR_EVEN) ? ^shift_q : ~^shift_q;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        par_bit_d  = par_bit_q;
        fs0_d      = fs0_q;
        vote_d     = vote_q;
        complete   = 1'b0;
        brk        = 1'b0;
        ferr_fin   = ferr_q | !bit_val;
        if (tick && sidx == S_V0) vote_d[0] = line;
        if (tick && sidx == S_V1) vote_d[1] = line;
        case (state_q)
            IDLE: begin
                if (fall) begin
                    state_d    = START;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                    par_bit_d  = 1'b0;
                    fs0_d      = 1'b0;
                end
            end
            START: begin
                if (mid && bit_val) state_d = IDLE;
                else if (bound)     state_d = DATA;
            end
            DATA: begin
                if (mid) shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                if (bound) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY == PAR_NONE) ? STOP : uart_pkg::PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            uart_pkg::PARITY: begin
                if (mid) begin
                    par_bit_d = bit_val;
                    perr_d    = (bit_val != par_exp);
                end
                if (bound) state_d = STOP;
            end
            STOP: begin
                if (mid) begin
                    if (!bit_val)         ferr_d = 1'b1;
                    if (stop_cnt_q == 1'b0) fs0_d = !bit_val;
                    if (stop_cnt_q == STOP_LAST) begin
                        // Leave at mid-stop so a slightly early next start is caught.
                        complete = 1'b1;
                        brk      = (shift_q == '0) && !par_bit_q &&
                                   ((stop_cnt_q == 1'b0) ? !bit_val : fs0_q);
                        state_d  = brk ? BRK_WAIT : IDLE;
                    end
                end else if (bound) begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                end
            end
            BRK_WAIT: begin
                if (line) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_perr_d  = m_perr_q;
        m_ferr_d  = m_ferr_q;
        m_brk_d   = m_brk_q;
        overrun_d = 1'b0;
        if (m_valid_q && m_ready) m_valid_d = 1'b0;
        if (complete) begin
            if (m_valid_q && !m_ready) begin
                overrun_d = 1'b1;
            end else begin
                m_valid_d = 1'b1;
                m_data_d  = shift_q;
                m_perr_d  = perr_q;
                m_ferr_d  = ferr_fin;
                m_brk_d   = brk;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            sync_q     <= '1;
            prev_q     <= 1'b1;
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            par_bit_q  <= 1'b0;
            fs0_q      <= 1'b0;
            vote_q     <= '0;
            m_data_q   <= '0;
            m_valid_q  <= 1'b0;
            m_perr_q   <= 1'b0;
            m_ferr_q   <= 1'b0;
            m_brk_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], rx_serial};
            prev_q     <= line;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            par_bit_q  <= par_bit_d;
            fs0_q      <= fs0_d;
            vote_q     <= vote_d;
            m_data_q   <= m_data_d;
            m_valid_q  <= m_valid_d;
            m_perr_q   <= m_perr_d;
            m_ferr_q   <= m_ferr_d;
            m_brk_q    <= m_brk_d;
            overrun_q  <= overrun_d;
        end
    end

    assign m_data       = m_data_q;
    assign m_valid      = m_valid_q;
    assign m_parity_err = m_perr_q;
    assign m_frame_err  = m_ferr_q;
    assign m_break      = m_brk_q;
    assign overrun      = overrun_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: a default 8N1 instance and a 7E2 instance.
module tb_uart_rx_os;

    localparam int BIT_A = 432;  // 27 clk/tick * 16
    localparam int BIT_B = 64;   // 4 clk/tick * 16

    logic       clk = 1'b0;
    logic       areset;
    logic       rx_a, rx_b, m_ready;
    logic [8:0] m_data_a;
    logic [6:0] m_data_b;
    logic       m_valid_a, m_parity_err_a, m_frame_err_a, m_break_a, overrun_a, busy_a;
    logic       m_valid_b, m_parity_err_b, m_frame_err_b, m_break_b, overrun_b, busy_b;

    int checks = 0;
    int errors = 0;
    int ovr_a  = 0;
    int ovr0;

    // Entry layout: {break, frame_err, parity_err, data[8:0]}
    logic [11:0] exp_q[$];
    logic [11:0] got_a_q[$];
    logic [11:0] got_b_q[$];

    always #5 clk = ~clk;

    uart_rx_os dut_a (
        .aclk         (clk),
        .areset       (areset),
        .rx_serial    (rx_a),
        .m_data       (m_data_a[7:0]),
        .m_valid      (m_valid_a),
        .m_ready      (m_ready),
        .m_parity_err (m_parity_err_a),
        .m_frame_err  (m_frame_err_a),
        .m_break      (m_break_a),
        .overrun      (overrun_a),
        .busy         (busy_a)
    );
    assign m_data_a[8] = 1'b0;

    uart_rx_os #(
        .CLK_HZ    (50_000_000),
        .BAUD      (781_250),
        .DATA_BITS (7),
        .PARITY    (uart_pkg::PAR_EVEN),
        .STOP_BITS (2)
    ) dut_b (
        .aclk         (clk),
        .areset       (areset),
        .rx_serial    (rx_b),
        .m_data       (m_data_b),
        .m_valid      (m_valid_b),
        .m_ready      (m_ready),
        .m_parity_err (m_parity_err_b),
        .m_frame_err  (m_frame_err_b),
        .m_break      (m_break_b),
        .overrun      (overrun_b),
        .busy         (busy_b)
    );

    // Every accepted character and every overrun cycle is recorded mid-cycle.
    always @(negedge clk) begin
        if (m_valid_a && m_ready)
            got_a_q.push_back({m_break_a, m_frame_err_a, m_parity_err_a, m_data_a});
        if (m_valid_b && m_ready)
            got_b_q.push_back({m_break_b, m_frame_err_b, m_parity_err_b, 2'b00, m_data_b});
        if (overrun_a) ovr_a++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // par < 0 means no parity bit; gbit >= 0 inverts one sample-width slice mid-bit.
    task automatic send_frame(input bit sel, input logic [8:0] data, input int nbits,
                              input int par, input int nstops, input logic stop_val,
                              input int gbit);
        int bc;
        bc = sel ? BIT_B : BIT_A;
        set_line(sel, 1'b0);
        tick(bc);
        for (int i = 0; i < nbits; i++) begin
            set_line(sel, data[i]);
            if (i == gbit) begin
                tick(230);
                set_line(sel, ~data[i]);
                tick(25);
                set_line(sel, data[i]);
                tick(bc - 255);
            end else begin
                tick(bc);
            end
        end
        if (par >= 0) begin
            set_line(sel, par[0]);
            tick(bc);
        end
        for (int i = 0; i < nstops; i++) begin
            set_line(sel, stop_val);
            tick(bc);
        end
    endtask

    task automatic check_next(input bit sel, input string tag);
        logic [11:0] exp, obs;
        int n;
        exp = exp_q.pop_front();
        n = 0;
        while ((sel ? got_b_q.size() : got_a_q.size()) == 0 && n < 1000) begin
            tick(1);
            n++;
        end
        checks++;
        assert ((sel ? got_b_q.size() : got_a_q.size()) != 0) else begin
            errors++;
            $error("FAIL %s: observed no character expected %h", tag, exp);
        end
        if ((sel ? got_b_q.size() : got_a_q.size()) != 0) begin
            obs = sel ? got_b_q.pop_front() : got_a_q.pop_front();
            check(tag, 32'(obs), 32'(exp));
        end
    endtask

    initial begin
        areset  = 1'b1;
        rx_a    = 1'b1;
        rx_b    = 1'b1;
        m_ready = 1'b1;
        tick(5);
        check("reset_outputs_a", 32'({m_valid_a, m_data_a, m_parity_err_a, m_frame_err_a,
                                      m_break_a, overrun_a, busy_a}), 32'h0);
        areset = 1'b0;
        tick(5);
        check("idle_outputs_b", 32'({m_valid_b, m_data_b, m_parity_err_b, m_frame_err_b,
                                     m_break_b, overrun_b, busy_b}), 32'h0);

        // Back-to-back clean frames
        ovr0 = ovr_a;
        send_frame(0, 9'h055, 8, -1, 1, 1'b1, -1);
        exp_q.push_back(12'h055);
        send_frame(0, 9'h0A3, 8, -1, 1, 1'b1, -1);
        exp_q.push_back(12'h0A3);
        check_next(0, "b2b_first_55");
        check_next(0, "b2b_second_a3");
        check("b2b_no_overrun", 32'(ovr_a - ovr0), 32'd0);

        // Stop bit forced low: framing error; line held low must not restart
        send_frame(0, 9'h03C, 8, -1, 1, 1'b0, -1);
        exp_q.push_back(12'h43C);
        check_next(0, "ferr_3c");
        tick(2 * BIT_A);
        check("ferr_low_idle_busy", 32'(busy_a), 32'd0);
        check("ferr_low_no_output", 32'(got_a_q.size()), 32'd0);
        set_line(0, 1'b1);
        tick(BIT_A);
        send_frame(0, 9'h081, 8, -1, 1, 1'b1, -1);
        exp_q.push_back(12'h081);
        check_next(0, "after_ferr_81");

        // 7E2: 0x41 has even weight, so correct parity is 0
        send_frame(1, 9'h041, 7, 1, 2, 1'b1, -1);
        exp_q.push_back(12'h241);
        check_next(1, "par_bad_41");
        send_frame(1, 9'h041, 7, 0, 2, 1'b1, -1);
        exp_q.push_back(12'h041);
        check_next(1, "par_good_41");

        // Break: 12 bit times low
        set_line(0, 1'b0);
        tick(12 * BIT_A);
        set_line(0, 1'b1);
        exp_q.push_back(12'hC00);
        check_next(0, "break_frame");
        tick(2 * BIT_A);
        check("break_single_output", 32'(got_a_q.size()), 32'd0);
        check("break_busy_clear", 32'(busy_a), 32'd0);

        // False starts
        set_line(0, 1'b0);
        tick(3);
        set_line(0, 1'b1);
        tick(BIT_A);
        check("glitch3_busy", 32'(busy_a), 32'd0);
        check("glitch3_no_output", 32'(got_a_q.size()), 32'd0);
        set_line(0, 1'b0);
        tick(130);
        set_line(0, 1'b1);
        tick(BIT_A);
        check("glitch_0p3_busy", 32'(busy_a), 32'd0);
        check("glitch_0p3_no_output", 32'(got_a_q.size()), 32'd0);

        // One-sample glitch inside data bit 6 is outvoted
        send_frame(0, 9'h0F0, 8, -1, 1, 1'b1, 6);
        exp_q.push_back(12'h0F0);
        check_next(0, "vote_f0");

        // Overrun: consumer stalled
        m_ready = 1'b0;
        ovr0 = ovr_a;
        send_frame(0, 9'h011, 8, -1, 1, 1'b1, -1);
        send_frame(0, 9'h022, 8, -1, 1, 1'b1, -1);
        tick(10);
        check("ovr_valid_held", 32'(m_valid_a), 32'd1);
        check("ovr_data_held", 32'(m_data_a), 32'h011);
        check("ovr_pulse_count", 32'(ovr_a - ovr0), 32'd1);
        m_ready = 1'b1;
        exp_q.push_back(12'h011);
        tick(1);
        check("ovr_valid_drop", 32'(m_valid_a), 32'd0);
        check_next(0, "ovr_transfer_11");

        // Reset mid-frame with a character pending
        m_ready = 1'b0;
        send_frame(0, 9'h033, 8, -1, 1, 1'b1, -1);
        tick(5);
        check("pre_reset_valid", 32'(m_valid_a), 32'd1);
        set_line(0, 1'b0);
        tick(3 * BIT_A);
        areset = 1'b1;
        #1;
        check("reset_mid_outputs", 32'({m_valid_a, m_data_a, m_parity_err_a, m_frame_err_a,
                                        m_break_a, overrun_a, busy_a}), 32'h0);
        set_line(0, 1'b1);
        tick(2);
        areset = 1'b0;
        m_ready = 1'b1;
        tick(5);
        check("post_reset_idle", 32'({m_valid_a, busy_a}), 32'h0);
        send_frame(0, 9'h07E, 8, -1, 1, 1'b1, -1);
        exp_q.push_back(12'h07E);
        check_next(0, "after_reset_7e");
        tick(BIT_A);
        check("final_no_extra", 32'(got_a_q.size() + got_b_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Parametrised oversampling UART receiver. It is the successor to the fixed 50 MHz / 115200 / 8N1 receive controller.
- Adds configurable data width, parity and stop bits, majority-vote sampling and false-start rejection.
- Reports framing, parity, break and overrun conditions.
- Sits between the board RX pin and the RX FIFO, presenting one character per valid/ready transfer.

Parameters:
CLK_HZ, 50_000_000, aclk frequency in Hz
BAUD, 115200, line rate in bit/s
OVERSAMPLE, 16, sample ticks per bit; even, >= 8
DATA_BITS, 8, character width, 5..9
PARITY, PAR_NONE, uart_pkg::parity_e: PAR_NONE / PAR_ODD / PAR_EVEN
STOP_BITS, 1, 1 or 2
SYNC_STAGES, 2, input synchroniser depth, >= 2

Ports:
aclk  in  1  clock
areset  in  1  reset; one clock; reset is asynchronous and active-high
rx_serial  in  1  asynchronous serial line, idle high
m_data  out  DATA_BITS  received character, LSB = first data bit
m_valid  out  1  character available
m_ready  in  1  consumer accepts
m_parity_err  out  1  qualifies m_data; parity mismatch
m_frame_err  out  1  qualifies m_data; a stop bit sampled 0
m_break  out  1  qualifies m_data; break condition
overrun  out  1  one-cycle pulse: completed character dropped
busy  out  1  state != IDLE

Behaviour:
- Reset:
  - all outputs 0
  - synchroniser flops preset to 1
  - state IDLE, all counters 0
  - reset mid-frame abandons the frame with no output
- Tick generator:
  - DIV = round(CLK_HZ / (BAUD*OVERSAMPLE)); elaborate-time error if DIV < 2.
  - Counter width = $clog2(DIV).
  - One-cycle tick when the counter reaches DIV-1; the counter then wraps to 0.
  - Counter and sample index reload to 0 on start-edge detection, so phase aligns to the edge.
- Sampling:
  - Sample index s runs 0..OVERSAMPLE-1 per bit, advancing on each tick.
  - Bit value = majority of the synchronised line at s = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - The bit is decided at s = OVERSAMPLE/2+1.
- States:
  - IDLE -> START on a synchronised falling edge (previous 1, current 0). A level 0 without an edge never starts a frame.
  - START:
    - at the start-bit decision, majority 1 -> IDLE (glitch rejected, no output)
    - else continue to the bit boundary (s = OVERSAMPLE-1), then -> DATA
  - DATA:
    - DATA_BITS bits, LSB first, shifted in at each decision
    - after the last boundary -> PARITY if PARITY != PAR_NONE, else -> STOP
  - PARITY:
    - expected bit = XOR(data) for even, ~XOR(data) for odd
    - mismatch sets perr
  - STOP:
    - decides STOP_BITS stop bits; any stop bit decided 0 sets ferr
    - on the last stop decision (mid-bit), the frame completes and the state leaves STOP:
      - break (data all 0, parity bit 0 if present, first stop 0) -> BRK_WAIT
      - else -> IDLE
    - exiting at mid-bit allows back-to-back frames with up to 0.5 bit early start.
  - BRK_WAIT: stay until the synchronised line = 1, then -> IDLE.
- Output register:
  - Frame completion is the cycle of the last stop decision.
  - m_valid rises on the following cycle (latency 1 clock from completion).
  - Latency from the start falling edge at the pin is SYNC_STAGES + frame cycles + 1.
  - m_data, m_parity_err, m_frame_err and m_break load together and are held stable while m_valid && !m_ready.
  - m_break implies m_frame_err = 1.
  - Transfer occurs when m_valid && m_ready; m_valid then drops next cycle unless a new completion is loaded in the same cycle.
- Simultaneous completion and transfer: the new character loads and m_valid stays 1.
- Completion while m_valid && !m_ready:
  - the new character is discarded
  - overrun pulses for 1 cycle
  - held data is unchanged

Decomposition:
- uart_pkg holds:
  - parity_e enum
  - rx_state_e (IDLE, START, DATA, PARITY, STOP, BRK_WAIT)
  - function calc_div(clk_hz, baud, os)
- Sub-module uart_baud_tick (parameters DIV and OVERSAMPLE; inputs restart and enable; outputs tick, sample index, mid and boundary strobes). It is reused by the future TX-side oversampled generator.
- The synchroniser stays inline.

Test Plan:
- Defaults (DIV=27, 432 clk/bit); send 0x55 then 0xA3 back-to-back with m_ready=1 -> two transfers, data 0x55 then 0xA3, all error flags 0, no overrun.
- Defaults; 0x3C with stop bit forced 0 -> m_data=0x3C, m_frame_err=1, m_break=0; next frame 0x81 received correctly only after the line returns high.
- PARITY=PAR_EVEN, DATA_BITS=7, STOP_BITS=2: send 0x41 with parity 1 (wrong) -> m_data=0x41, m_parity_err=1; resend with parity 0 -> m_parity_err=0.
- Line low for 12 bit times, then high -> one output, m_data=0x00, m_break=1, m_frame_err=1; no further output until the next falling edge.
- Low pulse of 3 clk and low pulse of 0.3 bit on the idle line -> no output, busy returns to 0 within 1 bit; single-sample glitch mid-data bit of 0xF0 -> still 0xF0.
- m_ready=0, send 0x11 then 0x22 -> m_data stays 0x11, overrun pulses once at 0x22 completion; m_ready=1 -> 0x11 transfers, m_valid=0. Assert areset mid-frame -> outputs 0, next 0x7E received cleanly.
